// File: rtl/uart_rx_param.sv
// Parametrised UART receiver: mid-bit sampling, false-start rejection, framing check
// and break-safe recovery. Optional parity checking is enabled by defining UART_RX_PARITY_EN.
`timescale 1ns/1ps

module uart_rx_param #(
  parameter int unsigned c_CYCLES_PER_BIT = 434,
  parameter int unsigned c_DATA_BITS      = 8,
  parameter int unsigned c_STOP_BITS      = 1,
  parameter int unsigned c_PARITY_ODD     = 0
) (
  input  logic                   i_CLK,
  input  logic                   i_RESET,
  input  logic                   i_SERIAL_DATA,
  output logic [c_DATA_BITS-1:0] o_DATA_RX,
  output logic                   o_RX_DATA_VALID,
  output logic                   o_FRAMING_ERR,
  output logic                   o_BUSY
`ifdef UART_RX_PARITY_EN
  ,
  output logic                   o_PARITY_ERR
`endif
);

  localparam int unsigned CNT_W = $clog2(c_CYCLES_PER_BIT);
  localparam int unsigned IDX_W = $clog2(c_DATA_BITS);
  localparam int unsigned HALF  = (c_CYCLES_PER_BIT - 1) / 2;

  localparam logic [CNT_W-1:0] CNT_MID   = CNT_W'(HALF);
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(c_CYCLES_PER_BIT - 1);
  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(c_DATA_BITS - 1);
  localparam logic             STOP_LAST = 1'(c_STOP_BITS - 1);

  // Reject illegal configurations at elaboration time
  if (c_CYCLES_PER_BIT < 4 || c_CYCLES_PER_BIT > 65535) begin : g_bad_cpb
    $error("uart_rx_param: c_CYCLES_PER_BIT out of range");
  end
  if (c_DATA_BITS < 5 || c_DATA_BITS > 9) begin : g_bad_bits
    $error("uart_rx_param: c_DATA_BITS out of range");
  end
  if (c_STOP_BITS < 1 || c_STOP_BITS > 2) begin : g_bad_stop
    $error("uart_rx_param: c_STOP_BITS must be 1 or 2");
  end
  if (c_PARITY_ODD > 1) begin : g_bad_odd
    $error("uart_rx_param: c_PARITY_ODD must be 0 or 1");
  end

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_START     = 3'd1,
    S_DATA      = 3'd2,
`ifdef UART_RX_PARITY_EN
    S_PARITY    = 3'd3,
`endif
    S_STOP      = 3'd4,
    S_WAIT_IDLE = 3'd5
  } state_t;

  state_t                 state_q;
  logic [1:0]             sync_q;
  logic [CNT_W-1:0]       cnt_q;
  logic [IDX_W-1:0]       idx_q;
  logic                   stop_idx_q;
  logic                   stop_bad_q;
  logic [c_DATA_BITS-1:0] shift_q;
  logic [c_DATA_BITS-1:0] data_q;
  logic                   valid_q;
  logic                   ferr_q;
  logic                   busy_q;
  logic                   rx_s;
  logic                   frame_bad_c;
  logic                   par_bad_c;

`ifdef UART_RX_PARITY_EN
  localparam logic ODD_BIT = 1'(c_PARITY_ODD);
  logic par_bit_q;
  logic perr_q;

  // Mismatch when received parity differs from XOR (even) or XNOR (odd) of the data
  assign par_bad_c    = (^shift_q) ^ par_bit_q ^ ODD_BIT;
  assign o_PARITY_ERR = perr_q;
`else
  assign par_bad_c    = 1'b0;
`endif

  assign rx_s        = sync_q[1];
  assign frame_bad_c = stop_bad_q | ~rx_s;

  assign o_DATA_RX       = data_q;
  assign o_RX_DATA_VALID = valid_q;
  assign o_FRAMING_ERR   = ferr_q;
  assign o_BUSY          = busy_q;

  // Two-flop synchronizer; resets to the idle line level
  always_ff @(posedge i_CLK or posedge i_RESET) begin
    if (i_RESET) begin
      sync_q <= 2'b11;
    end else begin
      sync_q <= {sync_q[0], i_SERIAL_DATA};
    end
  end

  // Receive FSM with registered outputs
  always_ff @(posedge i_CLK or posedge i_RESET) begin
    if (i_RESET) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      idx_q      <= '0;
      stop_idx_q <= 1'b0;
      stop_bad_q <= 1'b0;
      shift_q    <= '0;
      data_q     <= '0;
      valid_q    <= 1'b0;
      ferr_q     <= 1'b0;
      busy_q     <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_bit_q  <= 1'b0;
      perr_q     <= 1'b0;
`endif
    end else begin
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
`ifdef UART_RX_PARITY_EN
      perr_q  <= 1'b0;
`endif
      case (state_q)
        S_IDLE: begin
          if (!rx_s) begin
            state_q <= S_START;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
          end
        end

        S_START: begin
          if (cnt_q == CNT_MID) begin
            cnt_q <= '0;
            if (rx_s) begin
              state_q <= S_IDLE;
              busy_q  <= 1'b0;
            end else begin
              state_q <= S_DATA;
              idx_q   <= '0;
            end
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end

        S_DATA: begin
          if (cnt_q == CNT_LAST) begin
            cnt_q          <= '0;
            shift_q[idx_q] <= rx_s;
            if (idx_q == IDX_LAST) begin
`ifdef UART_RX_PARITY_EN
              state_q <= S_PARITY;
`else
              state_q <= S_STOP;
`endif
              stop_idx_q <= 1'b0;
              stop_bad_q <= 1'b0;
            end else begin
              idx_q <= idx_q + IDX_W'(1);
            end
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end

`ifdef UART_RX_PARITY_EN
        S_PARITY: begin
          if (cnt_q == CNT_LAST) begin
            cnt_q      <= '0;
            par_bit_q  <= rx_s;
            state_q    <= S_STOP;
            stop_idx_q <= 1'b0;
            stop_bad_q <= 1'b0;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
`endif

        S_STOP: begin
          if (cnt_q == CNT_LAST) begin
            cnt_q <= '0;
            // Every stop bit is sampled; the frame is judged at the centre of the last one
            if (stop_idx_q == STOP_LAST) begin
`ifdef UART_RX_PARITY_EN
              perr_q <= par_bad_c;
`endif
              if (frame_bad_c) begin
                ferr_q  <= 1'b1;
                state_q <= S_WAIT_IDLE;
              end else begin
                state_q <= S_IDLE;
                busy_q  <= 1'b0;
                if (!par_bad_c) begin
                  data_q  <= shift_q;
                  valid_q <= 1'b1;
                end
              end
            end else begin
              stop_idx_q <= 1'b1;
              stop_bad_q <= stop_bad_q | ~rx_s;
            end
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end

        S_WAIT_IDLE: begin
          // Hold off while the line is low so a break reports a single error
          if (rx_s) begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
          end
        end

        default: begin
          state_q <= S_IDLE;
          cnt_q   <= '0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx_param.sv
// Scoreboard bench for uart_rx_param: expected events are queued as frames are sent
// and popped when the receiver pulses valid or an error.
`timescale 1ns/1ps

module tb_uart_rx_param;

  localparam int C    = 16;
  localparam int HALF = (C - 1) / 2;
`ifdef UART_RX_PARITY_EN
  localparam int PAR  = 1;
`else
  localparam int PAR  = 0;
`endif

  localparam logic [2:0] K_OK = 3'b001;
  localparam logic [2:0] K_FE = 3'b010;
  localparam logic [2:0] K_PE = 3'b100;

  typedef struct {
    logic [2:0] kind;
    logic [8:0] data;
  } ev_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       serial;
  logic       serial7;
  logic [7:0] data;
  logic       valid, ferr, busy, perr;
  logic [6:0] data7;
  logic       valid7, ferr7, busy7;

  int   tests = 0;
  int   fails = 0;
  int   cyc   = 0;
  int   last_valid_cyc = 0;
  ev_t  exp_q[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  uart_rx_param #(.c_CYCLES_PER_BIT(C), .c_DATA_BITS(8), .c_STOP_BITS(1), .c_PARITY_ODD(0)) u_dut (
    .i_CLK(clk), .i_RESET(rst), .i_SERIAL_DATA(serial),
    .o_DATA_RX(data), .o_RX_DATA_VALID(valid), .o_FRAMING_ERR(ferr), .o_BUSY(busy)
`ifdef UART_RX_PARITY_EN
    , .o_PARITY_ERR(perr)
`endif
  );

`ifdef UART_RX_PARITY_EN
  logic perr7;
`else
  assign perr = 1'b0;
`endif

  uart_rx_param #(.c_CYCLES_PER_BIT(C), .c_DATA_BITS(7), .c_STOP_BITS(2), .c_PARITY_ODD(0)) u_dut7 (
    .i_CLK(clk), .i_RESET(rst), .i_SERIAL_DATA(serial7),
    .o_DATA_RX(data7), .o_RX_DATA_VALID(valid7), .o_FRAMING_ERR(ferr7), .o_BUSY(busy7)
`ifdef UART_RX_PARITY_EN
    , .o_PARITY_ERR(perr7)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic drive_bit(input int sel, input logic b);
    if (sel == 0) serial = b;
    else serial7 = b;
    tick(C);
  endtask

  task automatic send_frame(input int sel, input logic [8:0] d, input int nbits, input int nstop,
                            input logic [1:0] stop_vals, input logic par_flip);
    logic p;
    p = 1'b0;
    drive_bit(sel, 1'b0);
    for (int i = 0; i < nbits; i++) begin
      drive_bit(sel, d[i]);
      p = p ^ d[i];
    end
    if (PAR == 1) drive_bit(sel, p ^ par_flip);
    for (int s = 0; s < nstop; s++) drive_bit(sel, stop_vals[s]);
  endtask

  task automatic push(input logic [2:0] kind, input logic [8:0] d);
    ev_t e;
    e.kind = kind;
    e.data = d;
    exp_q.push_back(e);
  endtask

  task automatic wait_ev7(output logic [1:0] code, output logic [6:0] d);
    code = 2'b00;
    d    = '0;
    for (int i = 0; i < 14 * C; i++) begin
      @(negedge clk);
      if (valid7 || ferr7) begin
        code = {ferr7, valid7};
        d    = data7;
        break;
      end
    end
  endtask

  // Scoreboard: every output pulse must match the head of the expected queue
  always @(negedge clk) begin
    if (!rst && (valid || ferr || perr)) begin
      if (valid) last_valid_cyc = cyc;
      if (exp_q.size() == 0) begin
        chk("unexpected_event", 32'({perr, ferr, valid}), 32'd0);
      end else begin
        ev_t e;
        e = exp_q.pop_front();
        chk("event_kind", 32'({perr, ferr, valid}), 32'(e.kind));
        chk("event_data", 32'(data), 32'(e.data[7:0]));
      end
    end
  end

  initial begin
    int         t0;
    logic [1:0] code7;
    logic [6:0] d7;

    rst = 1'b1;
    serial = 1'b1;
    serial7 = 1'b1;
    tick(3);
    chk("reset_data", 32'(data), 32'd0);
    chk("reset_valid", 32'(valid), 32'd0);
    chk("reset_ferr", 32'(ferr), 32'd0);
    chk("reset_busy", 32'(busy), 32'd0);
    rst = 1'b0;
    tick(4);

    // Basic frame and valid latency from the start edge
    push(K_OK, 9'h026);
    t0 = cyc;
    send_frame(0, 9'h026, 8, 1, 2'b11, 1'b0);
    tick(2 * C);
    chk("latency", 32'(last_valid_cyc - t0), 32'(4 + HALF + C * (8 + 1 + PAR)));
    chk("idle_busy", 32'(busy), 32'd0);

    // Short low glitch is rejected at the mid-start check
    serial = 1'b0;
    tick(5);
    serial = 1'b1;
    chk("glitch_busy_hi", 32'(busy), 32'd1);
    tick(10);
    chk("glitch_busy_lo", 32'(busy), 32'd0);
    tick(2 * C);

    // Bad stop bit followed by a long break: one framing error, data held
    push(K_FE, 9'h026);
    send_frame(0, 9'h0A5, 8, 1, 2'b00, 1'b0);
    tick(40 * C);
    chk("break_busy", 32'(busy), 32'd1);
    serial = 1'b1;
    tick(2 * C);
    chk("break_drained", 32'(exp_q.size()), 32'd0);
    push(K_OK, 9'h03C);
    send_frame(0, 9'h03C, 8, 1, 2'b11, 1'b0);
    tick(2 * C);

    // Back-to-back frames with no idle gap
    push(K_OK, 9'h0A5);
    push(K_OK, 9'h05A);
    send_frame(0, 9'h0A5, 8, 1, 2'b11, 1'b0);
    send_frame(0, 9'h05A, 8, 1, 2'b11, 1'b0);
    tick(2 * C);
    chk("b2b_drained", 32'(exp_q.size()), 32'd0);

    // Reset during data bit 3 of 0xFF discards the partial frame
    serial = 1'b0;
    tick(C);
    serial = 1'b1;
    tick(3 * C + C / 2);
    rst = 1'b1;
    #1;
    chk("midrst_data", 32'(data), 32'd0);
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_valid", 32'(valid), 32'd0);
    tick(3);
    rst = 1'b0;
    tick(2 * C);
    push(K_OK, 9'h011);
    send_frame(0, 9'h011, 8, 1, 2'b11, 1'b0);
    tick(2 * C);

`ifdef UART_RX_PARITY_EN
    push(K_OK, 9'h026);
    send_frame(0, 9'h026, 8, 1, 2'b11, 1'b0);
    tick(2 * C);
    push(K_PE, 9'h026);
    send_frame(0, 9'h026, 8, 1, 2'b11, 1'b1);
    tick(2 * C);
    push(K_PE | K_FE, 9'h026);
    send_frame(0, 9'h0C3, 8, 1, 2'b00, 1'b1);
    serial = 1'b1;
    tick(2 * C);
`endif

    // 7 data bits, 2 stop bits: good frame, then second stop bit low
    fork
      send_frame(1, 9'h055, 7, 2, 2'b11, 1'b0);
      wait_ev7(code7, d7);
    join
    chk("d7_code", 32'(code7), 32'd1);
    chk("d7_data", 32'(d7), 32'h55);
    tick(2 * C);
    fork
      send_frame(1, 9'h02A, 7, 2, 2'b01, 1'b0);
      wait_ev7(code7, d7);
    join
    serial7 = 1'b1;
    chk("d7_ferr_code", 32'(code7), 32'd2);
    chk("d7_ferr_data", 32'(d7), 32'h55);
    tick(2 * C);
    chk("d7_busy", 32'(busy7), 32'd0);

    chk("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/uart_rx_param.md
Name: uart_rx_param

Overview:
Parametrised UART receiver and successor to the fixed 8-bit receiver used by the PONG serial input path. It supports configurable data width, one or two stop bits and mid-bit sampling with false-start rejection. It reports framing errors and applies break-safe recovery before rearming. It sits between the board RX pin and the game-control decoder, emitting one-cycle valid strobes with a held data word.

Parameters:
c_CYCLES_PER_BIT, 434, clock cycles per serial bit (50 MHz / 115200); legal range 4 to 65535.
c_DATA_BITS, 8, data bits per frame; legal range 5 to 9; sent LSB first.
c_STOP_BITS, 1, stop bits checked per frame; legal values 1 or 2.
c_PARITY_ODD, 0, parity sense when UART_RX_PARITY_EN is defined: 0 = even, 1 = odd; otherwise ignored.

Ports:
i_CLK  input  1  system clock; every flop is clocked on its rising edge.
i_RESET  input  1  asynchronous, active-high reset.
i_SERIAL_DATA  input  1  raw asynchronous serial line; idle high.
o_DATA_RX  output  c_DATA_BITS  last correctly received word; holds its value between frames.
o_RX_DATA_VALID  output  1  one-cycle pulse when o_DATA_RX is updated with a good frame.
o_FRAMING_ERR  output  1  one-cycle pulse when a stop bit is sampled low.
o_BUSY  output  1  high in every state except IDLE.
o_PARITY_ERR  output  1  present only with UART_RX_PARITY_EN; one-cycle pulse on parity mismatch.

Behaviour:
- Reset values: o_DATA_RX=0; o_RX_DATA_VALID, o_FRAMING_ERR, o_PARITY_ERR and o_BUSY all 0; state=IDLE; counters 0.
- Synchronizer: i_SERIAL_DATA passes through 2 flops that reset to 1. All decisions use the synchronized bit (rx_s), which adds 2 cycles of latency.
- Counters:
  - cycle counter width is clog2(c_CYCLES_PER_BIT); bit index width is clog2(c_DATA_BITS).
  - There is no wrap-around: the cycle counter clears on every state change and at every sample point.
- States: IDLE, START, DATA, PARITY (feature only), STOP, WAIT_IDLE.
- IDLE: the first cycle with rx_s=0 moves to START and clears the counter.
- START: at count (c_CYCLES_PER_BIT-1)/2 (mid start bit), resample rx_s:
  - rx_s=0: go to DATA with bit index 0.
  - rx_s=1: glitch; return to IDLE with no output pulse.
- DATA: every c_CYCLES_PER_BIT cycles after the mid-start point, shift rx_s into the shift register at bit index (LSB first).
  - After bit c_DATA_BITS-1 is sampled, go to PARITY (feature on) or STOP (feature off).
- STOP: sample each stop bit at its centre.
  - Any sampled 0: pulse o_FRAMING_ERR in the next cycle, leave o_DATA_RX unchanged, go to WAIT_IDLE.
  - All stop bits sampled 1 (and parity OK): load o_DATA_RX from the shift register and pulse o_RX_DATA_VALID in the same cycle, then return to IDLE.
- Latency: valid rises 1 cycle after the centre of the last stop bit, i.e. about 2 + (1.5 + c_DATA_BITS + c_STOP_BITS - 1)*c_CYCLES_PER_BIT cycles after the start edge.
- WAIT_IDLE: stay until rx_s=1 for one full cycle, then go to IDLE. A break condition (line held low) therefore yields exactly one framing error.
- Error priority: a parity error and a framing error in the same frame assert both pulses in the same cycle; valid is not asserted.
- Back-to-back frames: returning to IDLE at the mid-stop point lets a start edge immediately after the stop bit be accepted with no frame lost.
- Reset mid-frame: asynchronous return to IDLE, outputs cleared, partial data discarded; reception resumes on the next falling edge after release.

Optional Feature:
Macro UART_RX_PARITY_EN.
- Defined: one parity bit follows the data bits. The PARITY state samples it at its centre and compares it with the XOR of the data bits (XNOR when c_PARITY_ODD=1).
  - On mismatch, o_PARITY_ERR pulses together with the stop-bit decision and o_RX_DATA_VALID is suppressed.
  - Valid latency grows by c_CYCLES_PER_BIT.
- Undefined: no PARITY state and no o_PARITY_ERR port; frames carry no parity bit.

Test Plan:
- Defaults, send 0x26 (start, 0,1,1,0,0,1,0,0, stop) -> exactly one o_RX_DATA_VALID pulse with o_DATA_RX=0x26; o_FRAMING_ERR stays 0; o_BUSY returns to 0.
- c_CYCLES_PER_BIT=16, line low for 5 cycles then high -> no valid or error pulse; o_BUSY returns to 0 before cycle 16.
- Send 0xA5 with its stop bit forced low, then hold the line low for 40 bit times -> one o_FRAMING_ERR pulse, no valid, o_DATA_RX keeps its previous value; next 0x3C frame is received correctly.
- Back-to-back 0xA5 then 0x5A with zero idle gap -> two valid pulses carrying 0xA5 then 0x5A.
- Assert i_RESET during data bit 3 of 0xFF, release, send 0x11 -> outputs go to 0 immediately; only 0x11 is reported.
- UART_RX_PARITY_EN, even parity: send 0x26 with parity 1 -> valid with 0x26; send 0x26 with parity 0 -> o_PARITY_ERR pulse, no valid; c_DATA_BITS=7, c_STOP_BITS=2, send 0x55 -> valid with 0x55.
